toy_vdispatch: RTL and testbench

In-order vector instruction dispatcher that sits directly upstream of `toy_vcore`. It accepts one vector instruction per cycle over a valid/ready handshake and buffers it in a small FIFO. It checks per-unit occupancy and a per-register write scoreboard, then issues each instruction as a one-cycle `*_op_en` pulse on the matrix (`vmtx_*`), ALU (`valu_*`) or load/store (`vlsu_*`) port group of `toy_vcore`.

---
 rtl/toy_vdispatch.sv | 186 ++++++++++++++++++
 tb/tb_toy_vdispatch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_vdispatch.sv
// In-order vector instruction dispatcher feeding toy_vcore: buffers instructions,
// checks unit occupancy and a register write scoreboard, and issues one-cycle op pulses.
package toy_vpack;
  localparam int V_OPC_WIDTH     = 7;
  localparam int V_REG_IDX_WIDTH = 6;
endpackage

module toy_vdispatch
  import toy_vpack::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MTX_BUSY   = 4,
  parameter int ALU_BUSY   = 1,
  parameter int LSU_BUSY   = 2,
  parameter int WB_LAT     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vinst_vld,
  output logic                         vinst_rdy,
  input  logic [1:0]                   vinst_unit,
  input  logic [V_OPC_WIDTH-1:0]       vinst_opcode,
  input  logic [V_REG_IDX_WIDTH-1:0]   vinst_vs1,
  input  logic [V_REG_IDX_WIDTH-1:0]   vinst_vs2,
  input  logic [V_REG_IDX_WIDTH-1:0]   vinst_rd,
  input  logic                         vinst_rd_wr,
  output logic                         vmtx_op_en,
  output logic [V_OPC_WIDTH-1:0]       vmtx_opcode,
  output logic [V_REG_IDX_WIDTH-1:0]   vmtx_vs1,
  output logic [V_REG_IDX_WIDTH-1:0]   vmtx_vs2,
  output logic                         valu_op_en,
  output logic [V_OPC_WIDTH-1:0]       valu_opcode,
  output logic [V_REG_IDX_WIDTH-1:0]   valu_vs1,
  output logic [V_REG_IDX_WIDTH-1:0]   valu_vs2,
  output logic [4:0]                   valu_rd,
  output logic                         vlsu_op_en,
  output logic [V_OPC_WIDTH-1:0]       vlsu_opcode,
  output logic [V_REG_IDX_WIDTH-1:0]   vlsu_vs1,
  output logic [V_REG_IDX_WIDTH-1:0]   vlsu_vs2,
  output logic [V_REG_IDX_WIDTH-1:0]   vlsu_rd,
  output logic                         vinst_illegal,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
  output logic                         idle
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NREG   = 2 ** V_REG_IDX_WIDTH;
  localparam int SB_W   = $clog2(WB_LAT + 1);
  localparam int BUSY_W = $clog2(MTX_BUSY + ALU_BUSY + LSU_BUSY + 1);
  localparam logic [1:0] U_MTX = 2'd0;
  localparam logic [1:0] U_ALU = 2'd1;
  localparam logic [1:0] U_LSU = 2'd2;
  localparam logic [1:0] U_ILL = 2'd3;

  typedef struct packed {
    logic [1:0]                 unit;
    logic [V_OPC_WIDTH-1:0]     opc;
    logic [V_REG_IDX_WIDTH-1:0] vs1;
    logic [V_REG_IDX_WIDTH-1:0] vs2;
    logic [V_REG_IDX_WIDTH-1:0] rd;
    logic                       rd_wr;
  } inst_t;

  inst_t                fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [BUSY_W-1:0]    mtx_busy, alu_busy, lsu_busy;
  logic [SB_W-1:0]      sb_cnt [NREG];
  inst_t                head;
  logic                 empty, full, push, pop;
  logic                 unit_free, hazard, do_issue, drop_ill, sb_any;

  assign head  = fifo_mem[rd_ptr];
  assign empty = (fifo_cnt == '0);
  assign full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push  = vinst_vld && !full;

  always_comb begin
    unit_free = 1'b0;
    case (head.unit)
      U_MTX:   unit_free = (mtx_busy == '0);
      U_ALU:   unit_free = (alu_busy == '0);
      U_LSU:   unit_free = (lsu_busy == '0);
      default: unit_free = 1'b0;
    endcase
  end

  // rd is checked only for writers: a WAW must wait for the earlier write to retire
  assign hazard   = (sb_cnt[head.vs1] != '0) || (sb_cnt[head.vs2] != '0) ||
                    (head.rd_wr && (sb_cnt[head.rd] != '0));
  assign drop_ill = !empty && (head.unit == U_ILL);
  assign do_issue = !empty && (head.unit != U_ILL) && unit_free && !hazard;
  assign pop      = drop_ill || do_issue;

  always_comb begin
    sb_any = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (sb_cnt[i] != '0) sb_any = 1'b1;
    end
  end

  // Both status flags read low while reset is held
  assign vinst_rdy = rst_n && !full;
  assign idle      = rst_n && empty && (mtx_busy == '0) && (alu_busy == '0) &&
                     (lsu_busy == '0) && !sb_any;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{unit: vinst_unit, opc: vinst_opcode, vs1: vinst_vs1,
                            vs2: vinst_vs2, rd: vinst_rd, rd_wr: vinst_rd_wr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      mtx_busy      <= '0;
      alu_busy      <= '0;
      lsu_busy      <= '0;
      for (int i = 0; i < NREG; i++) sb_cnt[i] <= '0;
      vmtx_op_en    <= 1'b0;
      valu_op_en    <= 1'b0;
      vlsu_op_en    <= 1'b0;
      vinst_illegal <= 1'b0;
      vmtx_opcode   <= '0;
      vmtx_vs1      <= '0;
      vmtx_vs2      <= '0;
      valu_opcode   <= '0;
      valu_vs1      <= '0;
      valu_vs2      <= '0;
      valu_rd       <= '0;
      vlsu_opcode   <= '0;
      vlsu_vs1      <= '0;
      vlsu_vs2      <= '0;
      vlsu_rd       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (do_issue && head.unit == U_MTX) mtx_busy <= BUSY_W'(MTX_BUSY - 1);
      else if (mtx_busy != '0)            mtx_busy <= mtx_busy - BUSY_W'(1);
      if (do_issue && head.unit == U_ALU) alu_busy <= BUSY_W'(ALU_BUSY - 1);
      else if (alu_busy != '0)            alu_busy <= alu_busy - BUSY_W'(1);
      if (do_issue && head.unit == U_LSU) lsu_busy <= BUSY_W'(LSU_BUSY - 1);
      else if (lsu_busy != '0)            lsu_busy <= lsu_busy - BUSY_W'(1);

      for (int i = 0; i < NREG; i++) begin
        if (do_issue && head.rd_wr && head.rd == V_REG_IDX_WIDTH'(i))
          sb_cnt[i] <= SB_W'(WB_LAT);
        else if (sb_cnt[i] != '0)
          sb_cnt[i] <= sb_cnt[i] - SB_W'(1);
      end

      // Issue stage: only the selected group's fields move
      vmtx_op_en    <= do_issue && (head.unit == U_MTX);
      valu_op_en    <= do_issue && (head.unit == U_ALU);
      vlsu_op_en    <= do_issue && (head.unit == U_LSU);
      vinst_illegal <= drop_ill;
      if (do_issue && head.unit == U_MTX) begin
        vmtx_opcode <= head.opc;
        vmtx_vs1    <= head.vs1;
        vmtx_vs2    <= head.vs2;
      end
      if (do_issue && head.unit == U_ALU) begin
        valu_opcode <= head.opc;
        valu_vs1    <= head.vs1;
        valu_vs2    <= head.vs2;
        valu_rd     <= head.rd[4:0];
      end
      if (do_issue && head.unit == U_LSU) begin
        vlsu_opcode <= head.opc;
        vlsu_vs1    <= head.vs1;
        vlsu_vs2    <= head.vs2;
        vlsu_rd     <= head.rd;
      end
    end
  end

endmodule

// File: tb/tb_toy_vdispatch.sv
// Bench for toy_vdispatch: timestamp-based dispatch model checked every cycle,
// plus directed scenarios with hand-computed latencies and spacings.
module tb_toy_vdispatch;
  import toy_vpack::*;

  localparam int FIFO_DEPTH = 4;
  localparam int MTX_BUSY   = 4;
  localparam int ALU_BUSY   = 1;
  localparam int LSU_BUSY   = 2;
  localparam int WB_LAT     = 3;
  localparam int NREG       = 2 ** V_REG_IDX_WIDTH;

  logic clk, rst_n;
  logic vinst_vld, vinst_rdy, vinst_rd_wr;
  logic [1:0] vinst_unit;
  logic [V_OPC_WIDTH-1:0] vinst_opcode;
  logic [V_REG_IDX_WIDTH-1:0] vinst_vs1, vinst_vs2, vinst_rd;
  logic vmtx_op_en, valu_op_en, vlsu_op_en, vinst_illegal, idle;
  logic [V_OPC_WIDTH-1:0] vmtx_opcode, valu_opcode, vlsu_opcode;
  logic [V_REG_IDX_WIDTH-1:0] vmtx_vs1, vmtx_vs2, valu_vs1, valu_vs2, vlsu_vs1, vlsu_vs2, vlsu_rd;
  logic [4:0] valu_rd;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  toy_vdispatch #(.FIFO_DEPTH(FIFO_DEPTH), .MTX_BUSY(MTX_BUSY), .ALU_BUSY(ALU_BUSY),
                  .LSU_BUSY(LSU_BUSY), .WB_LAT(WB_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .vinst_vld(vinst_vld), .vinst_rdy(vinst_rdy),
    .vinst_unit(vinst_unit), .vinst_opcode(vinst_opcode), .vinst_vs1(vinst_vs1),
    .vinst_vs2(vinst_vs2), .vinst_rd(vinst_rd), .vinst_rd_wr(vinst_rd_wr),
    .vmtx_op_en(vmtx_op_en), .vmtx_opcode(vmtx_opcode), .vmtx_vs1(vmtx_vs1), .vmtx_vs2(vmtx_vs2),
    .valu_op_en(valu_op_en), .valu_opcode(valu_opcode), .valu_vs1(valu_vs1), .valu_vs2(valu_vs2),
    .valu_rd(valu_rd), .vlsu_op_en(vlsu_op_en), .vlsu_opcode(vlsu_opcode), .vlsu_vs1(vlsu_vs1),
    .vlsu_vs2(vlsu_vs2), .vlsu_rd(vlsu_rd), .vinst_illegal(vinst_illegal),
    .fifo_cnt(fifo_cnt), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model (timestamps of op_en cycles) ----------------
  typedef struct { int unit; int opc; int vs1; int vs2; int rd; bit wr; int sample; } ent_t;
  ent_t q[$];
  ent_t h;
  int last_u[3];
  int last_w[NREG];
  int e_en[3];
  int e_ill, e_rdy, e_idle;
  int e_mo, e_m1, e_m2, e_ao, e_a1, e_a2, e_ar, e_lo, e_l1, e_l2, e_lr;
  int mtx_log[$], alu_log[$], lsu_log[$], ill_log[$], mtx_opc_log[$];
  bit saw_full = 0;

  function automatic int busy_of(input int u);
    return (u == 0) ? MTX_BUSY : (u == 1) ? ALU_BUSY : LSU_BUSY;
  endfunction
  function automatic bit reg_free(input int r);
    return cyc >= last_w[r] + WB_LAT + 1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      for (int u = 0; u < 3; u++) last_u[u] = -1000;
      for (int r = 0; r < NREG; r++) last_w[r] = -1000;
      {e_mo, e_m1, e_m2, e_ao, e_a1, e_a2, e_ar, e_lo, e_l1, e_l2, e_lr} = '0;
      chk("rst_op_en", int'({vmtx_op_en, valu_op_en, vlsu_op_en, vinst_illegal}), 0);
      chk("rst_fifo_cnt", int'(fifo_cnt), 0);
      chk("rst_rdy", int'(vinst_rdy), 0);
      chk("rst_idle", int'(idle), 0);
      chk("rst_fields", int'(vmtx_opcode) + int'(vmtx_vs1) + int'(vmtx_vs2) + int'(valu_opcode) +
          int'(valu_vs1) + int'(valu_vs2) + int'(valu_rd) + int'(vlsu_opcode) + int'(vlsu_vs1) +
          int'(vlsu_vs2) + int'(vlsu_rd), 0);
    end else begin
      e_en = '{0, 0, 0};
      e_ill = 0;
      if (q.size() > 0 && q[0].sample <= cyc - 2) begin
        h = q[0];
        if (h.unit == 3) begin
          e_ill = 1;
          void'(q.pop_front());
        end else if (cyc >= last_u[h.unit] + busy_of(h.unit) && reg_free(h.vs1) &&
                     reg_free(h.vs2) && (!h.wr || reg_free(h.rd))) begin
          e_en[h.unit] = 1;
          last_u[h.unit] = cyc;
          if (h.wr) last_w[h.rd] = cyc;
          if (h.unit == 0) begin e_mo = h.opc; e_m1 = h.vs1; e_m2 = h.vs2; end
          if (h.unit == 1) begin e_ao = h.opc; e_a1 = h.vs1; e_a2 = h.vs2; e_ar = h.rd % 32; end
          if (h.unit == 2) begin e_lo = h.opc; e_l1 = h.vs1; e_l2 = h.vs2; e_lr = h.rd; end
          void'(q.pop_front());
        end
      end
      e_rdy = (q.size() < FIFO_DEPTH) ? 1 : 0;
      e_idle = (q.size() == 0) ? 1 : 0;
      for (int u = 0; u < 3; u++) if (cyc < last_u[u] + busy_of(u) - 1) e_idle = 0;
      for (int r = 0; r < NREG; r++) if (cyc < last_w[r] + WB_LAT) e_idle = 0;

      chk("mtx_op_en", int'(vmtx_op_en), e_en[0]);
      chk("alu_op_en", int'(valu_op_en), e_en[1]);
      chk("lsu_op_en", int'(vlsu_op_en), e_en[2]);
      chk("illegal", int'(vinst_illegal), e_ill);
      chk("mtx_opcode", int'(vmtx_opcode), e_mo);
      chk("mtx_vs1", int'(vmtx_vs1), e_m1);
      chk("mtx_vs2", int'(vmtx_vs2), e_m2);
      chk("alu_opcode", int'(valu_opcode), e_ao);
      chk("alu_vs1", int'(valu_vs1), e_a1);
      chk("alu_vs2", int'(valu_vs2), e_a2);
      chk("alu_rd", int'(valu_rd), e_ar);
      chk("lsu_opcode", int'(vlsu_opcode), e_lo);
      chk("lsu_vs1", int'(vlsu_vs1), e_l1);
      chk("lsu_vs2", int'(vlsu_vs2), e_l2);
      chk("lsu_rd", int'(vlsu_rd), e_lr);
      chk("fifo_cnt", int'(fifo_cnt), q.size());
      chk("rdy", int'(vinst_rdy), e_rdy);
      chk("idle", int'(idle), e_idle);

      if (vmtx_op_en) begin mtx_log.push_back(cyc); mtx_opc_log.push_back(int'(vmtx_opcode)); end
      if (valu_op_en) alu_log.push_back(cyc);
      if (vlsu_op_en) lsu_log.push_back(cyc);
      if (vinst_illegal) ill_log.push_back(cyc);
      if (fifo_cnt == FIFO_DEPTH && !vinst_rdy) saw_full = 1;

      if (vinst_vld && e_rdy == 1)
        q.push_back('{int'(vinst_unit), int'(vinst_opcode), int'(vinst_vs1), int'(vinst_vs2),
                      int'(vinst_rd), vinst_rd_wr, cyc});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int u, input int opc, input int vs1, input int vs2,
                      input int rd, input bit wr, output int sc);
    vinst_unit   = 2'(u);
    vinst_opcode = V_OPC_WIDTH'(opc);
    vinst_vs1    = V_REG_IDX_WIDTH'(vs1);
    vinst_vs2    = V_REG_IDX_WIDTH'(vs2);
    vinst_rd     = V_REG_IDX_WIDTH'(rd);
    vinst_rd_wr  = wr;
    vinst_vld    = 1'b1;
    sc = -1;
    for (int k = 0; k < 200 && sc < 0; k++) begin
      @(negedge clk);
      if (vinst_rdy) sc = cyc;
      @(posedge clk); #1;
    end
    vinst_vld = 1'b0;
    if (sc < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int k = 0; k < 300 && c < 0; k++) begin
      @(negedge clk);
      if (idle) c = cyc;
    end
    if (c < 0) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    mtx_log.delete(); alu_log.delete(); lsu_log.delete(); ill_log.delete(); mtx_opc_log.delete();
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int s0, s1, s2, s3, s4, s5, ic;
  int sv[6];

  initial begin
    rst_n = 1'b1;
    vinst_vld = 1'b0; vinst_unit = '0; vinst_opcode = '0;
    vinst_vs1 = '0; vinst_vs2 = '0; vinst_rd = '0; vinst_rd_wr = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    while (cyc < 10) begin @(posedge clk); #1; end

    // Single ALU op
    clear_logs();
    send(1, 5, 1, 2, 3, 1, s0);
    wait_idle(ic);
    chk("t1_sample_cycle", s0, 10);
    chk("t1_alu_count", alu_log.size(), 1);
    if (alu_log.size() == 1) begin
      chk("t1_alu_cycle", alu_log[0], 12);
      chk("t1_idle_after", ic - alu_log[0], 3);
    end
    chk("t1_opcode", int'(valu_opcode), 5);
    chk("t1_rd", int'(valu_rd), 3);

    // Three independent MTX ops
    clear_logs();
    send(0, 1, 10, 11, 0, 0, s0);
    send(0, 2, 12, 13, 0, 0, s1);
    send(0, 3, 14, 15, 0, 0, s2);
    wait_idle(ic);
    chk("t2_accept_gap1", s1 - s0, 1);
    chk("t2_accept_gap2", s2 - s1, 1);
    chk("t2_mtx_count", mtx_log.size(), 3);
    if (mtx_log.size() == 3) begin
      chk("t2_first_lat", mtx_log[0] - s0, 2);
      chk("t2_space1", mtx_log[1] - mtx_log[0], 4);
      chk("t2_space2", mtx_log[2] - mtx_log[1], 4);
    end

    // LSU load to r4 then RAW ALU consumer
    clear_logs();
    send(2, 7, 20, 21, 4, 1, s0);
    send(1, 9, 4, 22, 23, 1, s1);
    wait_idle(ic);
    chk("t3_counts", lsu_log.size() * 10 + alu_log.size(), 11);
    if (lsu_log.size() == 1 && alu_log.size() == 1)
      chk("t3_raw_gap", alu_log[0] - lsu_log[0], 4);
    chk("t3_lsu_rd", int'(vlsu_rd), 4);

    // Fill the FIFO with MTX ops stalled on the busy unit
    clear_logs();
    saw_full = 0;
    for (int i = 0; i < 6; i++) send(0, 40 + i, 0, 0, 0, 0, sv[i]);
    wait_idle(ic);
    chk("t4_saw_full", int'(saw_full), 1);
    chk("t4_resume_gap", sv[5] - sv[4], 2);
    chk("t4_mtx_count", mtx_opc_log.size(), 6);
    for (int i = 0; i < 6 && i < mtx_opc_log.size(); i++) chk("t4_order", mtx_opc_log[i], 40 + i);

    // Illegal op sandwiched between two ALU ops
    clear_logs();
    send(1, 8, 30, 31, 32, 0, s0);
    send(3, 99, 0, 0, 0, 1, s1);
    send(1, 9, 33, 34, 35, 0, s2);
    wait_idle(ic);
    chk("t5_ill_count", ill_log.size(), 1);
    chk("t5_alu_count", alu_log.size(), 2);
    if (ill_log.size() == 1 && alu_log.size() == 2) begin
      chk("t5_alu_then_ill", ill_log[0] - alu_log[0], 1);
      chk("t5_ill_then_alu", alu_log[1] - ill_log[0], 1);
    end

    // Reset in the middle of queued, hazard-stalled work
    clear_logs();
    send(2, 11, 40, 41, 7, 1, s0);
    send(1, 12, 7, 42, 8, 1, s1);
    send(1, 13, 8, 43, 44, 0, s2);
    send(0, 14, 8, 45, 0, 0, s3);
    chk("t6_cnt_before_rst", int'(fifo_cnt), 3);
    chk("t6_idle_before_rst", int'(idle), 0);
    rst_n = 1'b0;
    #1;
    chk("t6_op_en_in_rst", int'({vmtx_op_en, valu_op_en, vlsu_op_en}), 0);
    chk("t6_cnt_in_rst", int'(fifo_cnt), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    send(1, 15, 7, 8, 9, 1, s4);
    wait_idle(ic);
    chk("t6_alu_count", alu_log.size(), 1);
    if (alu_log.size() == 1) chk("t6_post_rst_lat", alu_log[0] - s4, 2);
    chk("t6_other_units", mtx_log.size() + lsu_log.size(), 0);
    s5 = 0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
